// File: rtl/fs_pkg.sv
// fs_pkg: shared definitions for the FAST-9 non-maximum suppression stage.
// Holds the scan FSM state type, default geometry, 3x3 window slot indices
// and the local-maximum test applied to each evaluated window.
package fs_pkg;

  localparam int SCORE_W    = 8;
  localparam int DEF_IMG_W  = 160;
  localparam int DEF_IMG_H  = 120;
  localparam int DEF_ADDR_W = 15;

  // Window slots, raster order: top row, middle row, bottom row.
  localparam int WIN_NW = 0;
  localparam int WIN_N  = 1;
  localparam int WIN_NE = 2;
  localparam int WIN_W  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_E  = 5;
  localparam int WIN_SW = 6;
  localparam int WIN_S  = 7;
  localparam int WIN_SE = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } nmsState_t;

  typedef logic [8:0][SCORE_W-1:0] window_t;

  // Neighbours that precede the centre in raster order must be strictly
  // smaller; later ones may tie. Of a run of equal scores only the first
  // in raster order survives.
  function automatic logic isLocalMax(input window_t w);
    logic [SCORE_W-1:0] ctr;
    ctr = w[WIN_C];
    return (ctr != {SCORE_W{1'b0}}) &&
           (ctr >  w[WIN_NW]) && (ctr >  w[WIN_N]) &&
           (ctr >  w[WIN_NE]) && (ctr >  w[WIN_W]) &&
           (ctr >= w[WIN_E])  && (ctr >= w[WIN_SW]) &&
           (ctr >= w[WIN_S])  && (ctr >= w[WIN_SE]);
  endfunction

endpackage

// File: rtl/fs_nms_linebuf.sv
// fs_nms_linebuf: two IMG_W-deep byte line buffers holding the previous two
// image rows. Reads are combinational at column `col`; a write at `col`
// pushes the column down (line2 <= line1, line1 <= wrData).
// Ports: clock, wrEn (column update strobe), col (column index),
//        wrData (newest row datum), line1Data (row r-1), line2Data (row r-2).
// Contents need no reset: the window is only evaluated once both rows
// have been written during the current scan.
module fs_nms_linebuf
  import fs_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int COL_W = $clog2(DEF_IMG_W)
) (
  input  logic               clock,
  input  logic               wrEn,
  input  logic [COL_W-1:0]   col,
  input  logic [SCORE_W-1:0] wrData,
  output logic [SCORE_W-1:0] line1Data,
  output logic [SCORE_W-1:0] line2Data
);

  logic [SCORE_W-1:0] line1_r [IMG_W];
  logic [SCORE_W-1:0] line2_r [IMG_W];

  assign line1Data = line1_r[col];
  assign line2Data = line2_r[col];

  // Column read-modify-write: shift the stored column down one row.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      line2_r[col] <= line1_r[col];
      line1_r[col] <= wrData;
    end
  end

endmodule

// File: rtl/fs_nms.sv
// fs_nms: non-maximum suppression over the FAST-9 score SRAM.
// On start, reads every score in raster order, slides a 3x3 window over the
// stream and emits interior local maxima as {address, score} records.
// Ports: clock, nReset (async active-low), start/busy/done (scan control),
//        rdEn/rdAddr/rdData (score SRAM, 1-cycle read latency),
//        cornerValid/cornerReady/cornerAddr/cornerScore (record output),
//        cornerCount (saturating count of records in this scan).
module fs_nms
  import fs_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rdEn,
  output logic [ADDR_W-1:0]  rdAddr,
  input  logic [SCORE_W-1:0] rdData,
  output logic               cornerValid,
  input  logic               cornerReady,
  output logic [ADDR_W-1:0]  cornerAddr,
  output logic [SCORE_W-1:0] cornerScore,
  output logic [15:0]        cornerCount
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H-1);
  // Offset from the arriving pixel (r,c) back to the window centre (r-1,c-1).
  localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W+1);

  nmsState_t          state_r, stateNext_s;
  logic [ADDR_W-1:0]  rdAddr_r;
  logic               rdValid_r;
  logic [SCORE_W-1:0] hold_r;
  logic               holdValid_r;
  logic [COL_W-1:0]   colCnt_r;
  logic [ROW_W-1:0]   rowCnt_r;
  logic [ADDR_W-1:0]  pixAddr_r;
  window_t            win_r, winNext_s;
  logic               cornerValid_r;
  logic [ADDR_W-1:0]  cornerAddr_r;
  logic [SCORE_W-1:0] cornerScore_r;
  logic [15:0]        cornerCount_r;
  logic               busy_r, done_r;

  logic               adv_s, rdEn_s, startAcc_s;
  logic               inValid_s, consume_s, hit_s;
  logic [SCORE_W-1:0] inData_s, line1Data_s, line2Data_s;

  assign adv_s      = !(cornerValid_r && !cornerReady);
  assign startAcc_s = (state_r == S_IDLE) && start;
  // A held datum is always older than anything on rdData: no read is
  // issued while stalled, so the two never coexist.
  assign inValid_s  = rdValid_r || holdValid_r;
  assign inData_s   = holdValid_r ? hold_r : rdData;
  assign consume_s  = inValid_s && adv_s;

  fs_nms_linebuf #(.IMG_W(IMG_W), .COL_W(COL_W)) uLineBuf (
    .clock     (clock),
    .wrEn      (consume_s),
    .col       (colCnt_r),
    .wrData    (inData_s),
    .line1Data (line1Data_s),
    .line2Data (line2Data_s)
  );

  // Window after shifting in the column {line2[c], line1[c], datum}.
  always_comb begin
    winNext_s         = win_r;
    winNext_s[WIN_NW] = win_r[WIN_N];
    winNext_s[WIN_N]  = win_r[WIN_NE];
    winNext_s[WIN_NE] = line2Data_s;
    winNext_s[WIN_W]  = win_r[WIN_C];
    winNext_s[WIN_C]  = win_r[WIN_E];
    winNext_s[WIN_E]  = line1Data_s;
    winNext_s[WIN_SW] = win_r[WIN_S];
    winNext_s[WIN_S]  = win_r[WIN_SE];
    winNext_s[WIN_SE] = inData_s;
  end

  assign hit_s = consume_s && (rowCnt_r >= ROW_W'(2)) && (colCnt_r >= COL_W'(2)) &&
                 isLocalMax(winNext_s);

  // Next-state and read-strobe decode.
  always_comb begin
    stateNext_s = state_r;
    rdEn_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) stateNext_s = S_SCAN;
        else       stateNext_s = S_IDLE;
      end
      S_SCAN: begin
        rdEn_s = adv_s;
        if (adv_s && (rdAddr_r == LAST_ADDR)) stateNext_s = S_DRAIN;
        else                                  stateNext_s = S_SCAN;
      end
      S_DRAIN: begin
        // Finish once the last datum is consumed and no record is left waiting.
        if (!rdValid_r && !holdValid_r && adv_s) stateNext_s = S_DONE;
        else                                     stateNext_s = S_DRAIN;
      end
      S_DONE:  stateNext_s = S_IDLE;
      default: stateNext_s = S_IDLE;
    endcase
  end

  // FSM state plus registered busy/done flags.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      busy_r  <= (stateNext_s != S_IDLE);
      done_r  <= (stateNext_s == S_DONE);
    end
  end

  // Read address, read-return tracking and stall hold register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rdAddr_r    <= {ADDR_W{1'b0}};
      rdValid_r   <= 1'b0;
      hold_r      <= {SCORE_W{1'b0}};
      holdValid_r <= 1'b0;
    end else begin
      rdValid_r <= rdEn_s;
      if (startAcc_s)                          rdAddr_r <= {ADDR_W{1'b0}};
      else if (rdEn_s && rdAddr_r != LAST_ADDR) rdAddr_r <= rdAddr_r + ADDR_W'(1);
      if (rdValid_r && !adv_s) begin
        hold_r      <= rdData;
        holdValid_r <= 1'b1;
      end else if (holdValid_r && adv_s) begin
        holdValid_r <= 1'b0;
      end
    end
  end

  // Position of the arriving datum and the 3x3 window registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      colCnt_r  <= {COL_W{1'b0}};
      rowCnt_r  <= {ROW_W{1'b0}};
      pixAddr_r <= {ADDR_W{1'b0}};
      win_r     <= {(9*SCORE_W){1'b0}};
    end else if (startAcc_s) begin
      colCnt_r  <= {COL_W{1'b0}};
      rowCnt_r  <= {ROW_W{1'b0}};
      pixAddr_r <= {ADDR_W{1'b0}};
    end else if (consume_s) begin
      win_r     <= winNext_s;
      pixAddr_r <= pixAddr_r + ADDR_W'(1);
      if (colCnt_r == COL_W'(IMG_W-1)) begin
        colCnt_r <= {COL_W{1'b0}};
        rowCnt_r <= rowCnt_r + ROW_W'(1);
      end else begin
        colCnt_r <= colCnt_r + COL_W'(1);
      end
    end
  end

  // Corner output register and saturating record counter.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cornerValid_r <= 1'b0;
      cornerAddr_r  <= {ADDR_W{1'b0}};
      cornerScore_r <= {SCORE_W{1'b0}};
      cornerCount_r <= 16'h0000;
    end else begin
      if (hit_s) begin
        cornerValid_r <= 1'b1;
        cornerAddr_r  <= pixAddr_r - CTR_OFS;
        cornerScore_r <= winNext_s[WIN_C];
      end else if (cornerReady) begin
        cornerValid_r <= 1'b0;
      end
      if (startAcc_s)                             cornerCount_r <= 16'h0000;
      else if (hit_s && cornerCount_r != 16'hFFFF) cornerCount_r <= cornerCount_r + 16'h0001;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign rdEn        = rdEn_s;
  assign rdAddr      = rdAddr_r;
  assign cornerValid = cornerValid_r;
  assign cornerAddr  = cornerAddr_r;
  assign cornerScore = cornerScore_r;
  assign cornerCount = cornerCount_r;

endmodule

// File: tb/tb_fs_nms.sv
// tb_fs_nms: scoreboard bench for fs_nms on a 6x5 image. A memory model
// answers reads; a reference model computes the expected corner list from
// the image; a monitor pops and compares each accepted record.
module tb_fs_nms;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int N  = W * H;
  localparam int AW = 5;

  typedef struct {
    int addr;
    int score;
  } rec_t;

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic          start = 1'b0;
  logic          cornerReady = 1'b1;
  logic [7:0]    rdData = 8'd0;
  logic          busy, done, rdEn, cornerValid;
  logic [AW-1:0] rdAddr, cornerAddr;
  logic [7:0]    cornerScore;
  logic [15:0]   cornerCount;

  logic [7:0] mem [N];
  rec_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         readyMode = 0;
  int         holdCnt = 0;

  fs_nms #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clock(clock), .nReset(nReset), .start(start), .busy(busy), .done(done),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
    .cornerValid(cornerValid), .cornerReady(cornerReady),
    .cornerAddr(cornerAddr), .cornerScore(cornerScore), .cornerCount(cornerCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Score SRAM: data one cycle after the read strobe.
  initial forever begin
    @(posedge clock);
    if (rdEn) rdData <= mem[rdAddr];
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = hold each record 5 cycles.
  initial forever begin
    @(posedge clock);
    #1;
    case (readyMode)
      0: cornerReady = 1'b1;
      1: cornerReady = ($urandom_range(0, 2) != 0);
      2: begin
        if (cornerValid && holdCnt < 5) begin
          cornerReady = 1'b0;
          holdCnt++;
        end else begin
          cornerReady = 1'b1;
          holdCnt = 0;
        end
      end
      default: cornerReady = 1'b1;
    endcase
  end

  // Monitor: record handshakes on the falling edge.
  initial begin
    logic stallPend;
    int   heldAddr, heldScore;
    rec_t e;
    stallPend = 1'b0;
    forever begin
      @(negedge clock);
      if (!nReset) begin
        stallPend = 1'b0;
      end else begin
        if (stallPend) begin
          check("stall_valid", cornerValid, 1);
          check("stall_addr", cornerAddr, heldAddr);
          check("stall_score", cornerScore, heldScore);
        end
        if (cornerValid && cornerReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got addr %0d score %0d, expected none", cornerAddr, cornerScore);
          end else begin
            e = expQ.pop_front();
            check("rec_addr", cornerAddr, e.addr);
            check("rec_score", cornerScore, e.score);
          end
          stallPend = 1'b0;
        end else if (cornerValid) begin
          stallPend = 1'b1;
          heldAddr  = cornerAddr;
          heldScore = cornerScore;
        end else begin
          stallPend = 1'b0;
        end
      end
    end
  end

  function automatic int pix(input int r, input int c);
    return mem[r*W + c];
  endfunction

  // Reference: interior pixel is a corner when nonzero, strictly above every
  // earlier (raster) neighbour and not below every later one.
  task automatic buildExpected(output int cnt);
    rec_t rec;
    int   ctr;
    bit   ok;
    cnt = 0;
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        ctr = pix(r, c);
        ok  = (ctr != 0);
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              if (dr < 0 || (dr == 0 && dc < 0)) ok = ok && (ctr >  pix(r+dr, c+dc));
              else                               ok = ok && (ctr >= pix(r+dr, c+dc));
            end
          end
        end
        if (ok) begin
          rec.addr  = r*W + c;
          rec.score = ctr;
          expQ.push_back(rec);
          cnt++;
        end
      end
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < N; i++) mem[i] = 8'd0;
  endtask

  task automatic randMem(input int maxVal);
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, maxVal));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdEn"}, rdEn, 0);
    check({tag, "_rdAddr"}, rdAddr, 0);
    check({tag, "_cornerValid"}, cornerValid, 0);
    check({tag, "_cornerAddr"}, cornerAddr, 0);
    check({tag, "_cornerScore"}, cornerScore, 0);
    check({tag, "_cornerCount"}, cornerCount, 0);
  endtask

  // One full scan. expLat < 0 skips the done-latency check; expCnt < 0 skips
  // the fixed record-count check (the model count is always checked).
  task automatic runScan(input string tag, input int expLat, input int expCnt);
    int  cyc;
    int  modelCnt;
    bit  seen;
    buildExpected(modelCnt);
    @(posedge clock);
    #1;
    start = 1'b1;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, "_busy_t1"}, busy, 1);
        check({tag, "_rdAddr_t1"}, rdAddr, 0);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", tag, cyc);
    end
    if (expLat >= 0) check({tag, "_done_latency"}, cyc, expLat);
    @(posedge clock);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_count_model"}, cornerCount, modelCnt);
    if (expCnt >= 0) check({tag, "_count"}, cornerCount, expCnt);
    check({tag, "_queue_left"}, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    clearMem();
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    @(negedge clock);
    nReset = 1'b1;

    // All-zero memory.
    readyMode = 0;
    runScan("zero", N + 3, 0);

    // Single isolated score at (2,3).
    clearMem();
    mem[15] = 8'd50;
    runScan("single", N + 3, 1);

    // Equal neighbours on one row: only one may survive.
    clearMem();
    mem[14] = 8'd40;
    mem[15] = 8'd40;
    runScan("tie", N + 3, 1);

    // Border pixels are never evaluated.
    clearMem();
    mem[0]  = 8'd90;
    mem[29] = 8'd90;
    runScan("border", N + 3, 0);

    // Three isolated maxima, each held 5 cycles downstream.
    clearMem();
    mem[7]  = 8'd30;
    mem[16] = 8'd60;
    mem[20] = 8'd45;
    readyMode = 2;
    runScan("stall", -1, 3);

    // Reset in the middle of a scan, then a clean scan.
    readyMode = 0;
    randMem(9);
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    nReset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    expQ.delete();
    @(negedge clock);
    nReset = 1'b1;
    runScan("after_reset", -1, -1);

    // Randomised images, small score range so ties are common.
    for (int it = 0; it < 8; it++) begin
      randMem((it % 2 == 0) ? 3 : 20);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 2) == 0) mem[i] = 8'd0;
      readyMode = (it < 2) ? 0 : 1;
      runScan("random", -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
